// File: rtl/adder_pkg.sv
// Shared definitions for the byte-serial adder sequencer: FSM encoding and byte width.
package adder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multibyte_add_sequencer.sv
// Byte-serial multi-precision adder controller: drives an external 8-bit adder
// LSB byte first, chaining the carry, and returns the full-width sum.
module multibyte_add_sequencer
  import adder_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*NBYTES-1:0]      in_a,
  input  logic [8*NBYTES-1:0]      in_b,
  input  logic                     in_cin,
  output logic [7:0]               add_a,
  output logic [7:0]               add_b,
  output logic                     add_cin,
  input  logic [7:0]               add_sum,
  input  logic                     add_cout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8*NBYTES-1:0]      out_sum,
  output logic                     out_cout
);

  localparam int IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t               state;
  logic [8*NBYTES-1:0]  a_reg;
  logic [8*NBYTES-1:0]  b_reg;
  logic [8*NBYTES-1:0]  sum_reg;
  logic                 carry;
  logic [IDX_W-1:0]     idx;
  logic                 cout_reg;
  logic                 in_ready_r;
  logic                 out_valid_r;

  // Handshake flags are kept as flops alongside state so they never see in_valid/out_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      sum_reg     <= '0;
      carry       <= 1'b0;
      idx         <= '0;
      cout_reg    <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg      <= in_a;
            b_reg      <= in_b;
            carry      <= in_cin;
            idx        <= '0;
            in_ready_r <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          sum_reg[BYTE_W*idx +: BYTE_W] <= add_sum;
          carry <= add_cout;
          if (idx == LAST_IDX) begin
            cout_reg    <= add_cout;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_reg[BYTE_W*idx +: BYTE_W];
      add_b   = b_reg[BYTE_W*idx +: BYTE_W];
      add_cin = carry;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_sum   = sum_reg;
  assign out_cout  = cout_reg;

endmodule
